d_reg_pipeline: RTL and testbench
=================================

// Module: d_reg_pipeline
// PURPOSE
//  Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register
//  delay line with clock enable, synchronous clear, per-stage valid tracking and occupancy count.
//  Used as the generic retiming/delay element between datapath blocks in the flow.
//  Replaces hand-chained flops; DEPTH=1, WIDTH=1 reduces to a plain D flip-flop plus valid.
// PARAMETERS
//  WIDTH     8  data width in bits (>=1)
//  DEPTH     4  number of register stages, i.e. latency in enabled cycles (>=1)
//  RESET_VAL 0  value loaded into every data stage on reset/clear (WIDTH bits)
// PORTS
//  clk      in   1                    rising-edge clock
//  rst_n    in   1                    asynchronous active-low reset
//  en       in   1                    advance enable; 0 = all stages hold
//  clr      in   1                    synchronous clear, priority over en
//  d        in   WIDTH                input data
//  d_valid  in   1                    input data qualifier
//  q        out  WIDTH                output of last stage (stage DEPTH-1)
//  q_valid  out  1                    valid bit of last stage
//  taps     out  WIDTH*DEPTH          all stages flattened; stage i at [i*WIDTH +: WIDTH]
//  occ      out  $clog2(DEPTH+1)      number of stages currently holding valid data
//  full     out  1                    occ == DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async, no clock needed): every stage = RESET_VAL, every valid = 0,
//    occ = 0, full = 0; hence q = RESET_VAL, q_valid = 0. Release takes effect on next edge.
//  - Priority per rising clk edge: rst_n low > clr > en > hold.
//  - clr=1: same state as reset, applied synchronously; d/d_valid on that edge are discarded.
//  - en=1, clr=0: stage[0] <= d, v[0] <= d_valid; stage[i] <= stage[i-1], v[i] <= v[i-1].
//    Data in stage DEPTH-1 is dropped (no backpressure; block never stalls upstream).
//  - en=0, clr=0: all stages, valids and occ hold exactly.
//  - Latency: d presented at enabled edge k appears on q after DEPTH enabled edges;
//    with en tied high, q(t) = d(t-DEPTH) cycles. Disabled edges do not count.
//  - Data stages shift regardless of d_valid; invalid slots carry whatever d was (not masked).
//  - occ updated on enabled edges only: occ_next = occ + d_valid - v[DEPTH-1].
//    Both in and out valid -> unchanged. Must always equal popcount(v); never exceeds DEPTH,
//    never underflows. full is combinational from occ.
//  - All outputs are registered or pure decodes of registers; no combinational d->q path.
//  - Reset asserted mid-stream: all in-flight data and valids lost immediately.
//  - DEPTH=1: single stage, occ is 1 bit, q/q_valid follow d/d_valid one enabled edge later.
// TESTING  (WIDTH=8, DEPTH=4, RESET_VAL=8'h00 unless stated)
//  1 Reset: drive rst_n=0 between edges with stages loaded -> q=00, q_valid=0, occ=0
//    immediately, no edge.
//  2 Latency: en=1, d_valid=1, d=01,02,03,04,05 on successive edges -> q=01 with
//    q_valid=1 on 4th edge after first push; then 02..05; full=1 from 4th edge.
//  3 Enable hold: after 2 pushes (AA,BB) drop en for 3 cycles -> taps/occ=2 frozen;
//    re-enable, AA on q after 2 more edges.
//  4 Valid bubbles: push d_valid pattern 1,0,1,1,0 with en=1 -> q_valid reproduces
//    the pattern delayed 4 cycles; occ never >4, always equals popcount of valids.
//  5 Clear priority: pipeline full, assert clr=1 with en=1, d_valid=1, d=FF -> next edge
//    q=00, occ=0, FF not captured.
//  6 Random: 200 cycles random en/clr/d/d_valid, rst_n pulsed once mid-run -> q/q_valid/occ
//    match reference queue model every cycle; repeat with DEPTH=1, WIDTH=1, RESET_VAL=1.

Source files
------------

// File: rtl/d_reg_pipeline.sv
// d_reg_pipeline: WIDTH-bit, DEPTH-stage register delay line with clock
// enable, synchronous clear, per-stage valid tracking and occupancy count.
// DEPTH=1, WIDTH=1 reduces to a plain D flip-flop plus a valid bit.
`timescale 1ns/1ps
module d_reg_pipeline #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [WIDTH-1:0]            d,
  input  logic                        d_valid,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  output logic [WIDTH*DEPTH-1:0]      taps,
  output logic [$clog2(DEPTH+1)-1:0]  occ,
  output logic                        full
);

  localparam int unsigned       OCC_W     = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0]  OCC_DEPTH = OCC_W'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] v;

  // Stage data, valids and occupancy: async reset > clear > enable > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      v   <= '0;
      occ <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      v   <= '0;
      occ <= '0;
    end else if (en) begin
      stage[0] <= d;
      v[0]     <= d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        v[i]     <= v[i-1];
      end
      // Occupancy tracks popcount(v) incrementally: +1 on entry, -1 on drop.
      if (d_valid && !v[DEPTH-1])
        occ <= occ + OCC_ONE;
      else if (!d_valid && v[DEPTH-1])
        occ <= occ - OCC_ONE;
    end
  end

  // Outputs are direct register views or decodes of registers.
  assign q       = stage[DEPTH-1];
  assign q_valid = v[DEPTH-1];
  assign full    = (occ == OCC_DEPTH);

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = stage[g];
  end

endmodule

// File: tb/tb_d_reg_pipeline.sv
// Directed and randomized checks for d_reg_pipeline in two configurations:
// WIDTH=8/DEPTH=4/RESET_VAL=00 and WIDTH=1/DEPTH=1/RESET_VAL=1.
`timescale 1ns/1ps
module tb_d_reg_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  // Instance A: WIDTH=8, DEPTH=4
  logic        en, clr, d_valid;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        q_valid;
  logic [31:0] taps;
  logic [2:0]  occ;
  logic        full;
  // Instance B: WIDTH=1, DEPTH=1, RESET_VAL=1
  logic        en_b, clr_b, d_valid_b;
  logic [0:0]  d_b, q_b, taps_b, occ_b;
  logic        q_valid_b, full_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .taps(taps), .occ(occ), .full(full)
  );

  d_reg_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b), .d(d_b), .d_valid(d_valid_b),
    .q(q_b), .q_valid(q_valid_b), .taps(taps_b), .occ(occ_b), .full(full_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs sampled and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference models: queues of {valid,data}, index 0 = stage 0.
  logic [8:0] ma[$];
  logic [1:0] mb[$];

  task automatic model_reset();
    ma.delete();
    mb.delete();
    for (int i = 0; i < 4; i++) ma.push_back(9'h000);
    mb.push_back(2'b01);
  endtask

  function automatic int pop_a();
    int n = 0;
    foreach (ma[i]) n += int'(ma[i][8]);
    return n;
  endfunction

  int exp_occ [9] = '{1, 1, 2, 3, 2, 2, 1, 0, 0};
  int exp_qv  [9] = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
  int pat     [9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0; en = 0; clr = 0; d_valid = 0; d = '0;
    en_b = 0; clr_b = 0; d_valid_b = 0; d_b = '0;
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_qv", q_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_full", full, 0);
    chk("rst_b_q", q_b, 1'b1);
    chk("rst_b_occ", occ_b, 0);
    rst_n = 1'b1;
    step();

    // Latency: 01..08 pushed; q follows 4 enabled edges later.
    en = 1; d_valid = 1;
    for (int k = 1; k <= 8; k++) begin
      d = 8'(k);
      step();
      if (k >= 4) begin
        chk("lat_q", q, 64'(k - 3));
        chk("lat_qv", q_valid, 1);
        chk("lat_occ", occ, 4);
        chk("lat_full", full, 1);
        if (k == 4) chk("lat_taps", taps, 32'h01020304);
      end else begin
        chk("lat_occ_fill", occ, 64'(k));
        chk("lat_full_fill", full, 0);
        chk("lat_qv_fill", q_valid, 0);
      end
    end

    // Async reset between edges with stages loaded.
    en = 0;
    rst_n = 1'b0;
    #2;
    chk("arst_q", q, 8'h00);
    chk("arst_qv", q_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_full", full, 0);
    chk("arst_taps", taps, 32'h0);
    rst_n = 1'b1;
    step();

    // Enable hold.
    en = 1; d_valid = 1; d = 8'hAA; step();
    d = 8'hBB; step();
    en = 0; d = 8'hCC;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_taps", taps, 32'h0000AABB);
      chk("hold_occ", occ, 2);
      chk("hold_qv", q_valid, 0);
    end
    en = 1; d_valid = 0; d = 8'h00;
    step();
    chk("rehold_qv1", q_valid, 0);
    step();
    chk("rehold_q", q, 8'hAA);
    chk("rehold_qv", q_valid, 1);
    chk("rehold_occ", occ, 2);

    // Valid bubbles from an empty pipeline.
    clr = 1; step(); clr = 0;
    chk("bub_clr_occ", occ, 0);
    for (int n = 0; n < 9; n++) begin
      d = 8'(8'h11 + n);
      d_valid = pat[n][0];
      step();
      chk("bub_occ", occ, 64'(exp_occ[n]));
      chk("bub_qv", q_valid, 64'(exp_qv[n]));
      if (n >= 3) chk("bub_q", q, 64'(8'h11 + n - 3));
    end

    // Clear priority over enable on a full pipeline.
    d_valid = 1;
    for (int k = 1; k <= 4; k++) begin d = 8'(8'h20 + k); step(); end
    chk("clr_pre_full", full, 1);
    clr = 1; en = 1; d_valid = 1; d = 8'hFF;
    step();
    chk("clr_q", q, 8'h00);
    chk("clr_qv", q_valid, 0);
    chk("clr_occ", occ, 0);
    chk("clr_taps", taps, 32'h0);
    clr = 0; en = 0;
    step();
    chk("clr_nocap_taps", taps, 32'h0);

    // Random run on both instances against queue models.
    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      en        = ($urandom_range(3) != 0);
      clr       = ($urandom_range(15) == 0);
      d_valid   = 1'($urandom_range(1));
      d         = 8'($urandom);
      en_b      = ($urandom_range(3) != 0);
      clr_b     = ($urandom_range(15) == 0);
      d_valid_b = 1'($urandom_range(1));
      d_b       = 1'($urandom_range(1));
      if (clr) begin
        ma.delete();
        for (int i = 0; i < 4; i++) ma.push_back(9'h000);
      end else if (en) begin
        ma.push_front({d_valid, d});
        void'(ma.pop_back());
      end
      if (clr_b) begin
        mb.delete();
        mb.push_back(2'b01);
      end else if (en_b) begin
        mb.push_front({d_valid_b, d_b});
        void'(mb.pop_back());
      end
      step();
      chk("rnd_q", q, ma[3][7:0]);
      chk("rnd_qv", q_valid, ma[3][8]);
      chk("rnd_occ", occ, 64'(pop_a()));
      chk("rnd_full", full, (pop_a() == 4));
      chk("rnd_b_q", q_b, mb[0][0]);
      chk("rnd_b_qv", q_valid_b, mb[0][1]);
      chk("rnd_b_occ", occ_b, mb[0][1]);
      if (c == 100) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rnd_arst_q", q, 8'h00);
        chk("rnd_arst_occ", occ, 0);
        chk("rnd_arst_b_q", q_b, 1'b1);
        chk("rnd_arst_b_qv", q_valid_b, 0);
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
